// File: rtl/reg_write_demux.sv
// reg_write_demux: 2-entry buffered, byte-masked write port for a 32x32 register bank.
// Define ZERO_REG_EN to hardwire register 0 to zero.
module reg_write_demux #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic [WIDTH/8-1:0]      wr_be,
    input  logic                    hold,
    output logic [DEPTH*WIDTH-1:0]  q_flat,
    output logic                    wr_done,
    output logic [ADDR_W-1:0]       done_addr,
    output logic                    busy
);
    localparam int NB = WIDTH / 8;

    logic [ADDR_W-1:0] f_addr [2];
    logic [WIDTH-1:0]  f_data [2];
    logic [NB-1:0]     f_be   [2];
    logic              wp, rp, push, pop;
    logic [1:0]        count, count_nxt;
    logic [DEPTH-1:0]  wen;

    assign wr_ready  = count < 2'd2;
    assign push      = wr_valid && wr_ready;
    assign pop       = (count != 2'd0) && !hold;
    assign count_nxt = count + {1'b0, push} - {1'b0, pop};

    // One-hot decode of the head entry's address, gated by commit
    always_comb begin
        for (int r = 0; r < DEPTH; r++) wen[r] = pop && (f_addr[rp] == ADDR_W'(r));
`ifdef ZERO_REG_EN
        wen[0] = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (push) begin
            f_addr[wp] <= wr_addr;
            f_data[wp] <= wr_data;
            f_be[wp]   <= wr_be;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp        <= 1'b0;
            rp        <= 1'b0;
            count     <= 2'd0;
            busy      <= 1'b0;
            wr_done   <= 1'b0;
            done_addr <= '0;
        end else begin
            wp      <= wp ^ push;
            rp      <= rp ^ pop;
            count   <= count_nxt;
            busy    <= count_nxt != 2'd0;
            wr_done <= pop;
            if (pop) done_addr <= f_addr[rp];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_reg
        logic [WIDTH-1:0] q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) q <= '0;
            else for (int k = 0; k < NB; k++)
                if (wen[g] && f_be[rp][k]) q[8*k +: 8] <= f_data[rp][8*k +: 8];
        end
        assign q_flat[g*WIDTH +: WIDTH] = q;
    end
endmodule
